// File: rtl/nes_pad_poller.sv
// NES/SNES multi-pad serial reader: shared latch/clock strobes, per-frame capture.
// Define NES_PAD_EDGE_DETECT_EN to add the 'pressed' new-press output.
module nes_pad_poller #(
   parameter int NUM_PADS    = 2,
   parameter int CLK_DIV     = 300,
   parameter int POLL_PERIOD = 1666667
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_PADS-1:0]   nes_data,
   output logic                  nes_latch,
   output logic                  nes_clk,
   output logic [8*NUM_PADS-1:0] buttons,
`ifdef NES_PAD_EDGE_DETECT_EN
   output logic [8*NUM_PADS-1:0] pressed,
`endif
   output logic                  valid
);

   localparam int TW = $clog2(POLL_PERIOD);
   localparam int CW = $clog2(2 * CLK_DIV);

   localparam logic [TW-1:0] T_LAST   = TW'(POLL_PERIOD - 1);
   localparam logic [CW-1:0] C_LAST   = CW'(2 * CLK_DIV - 1);
   localparam logic [CW-1:0] C_HIGH   = CW'(CLK_DIV);
   localparam logic [CW-1:0] C_SAMPLE = CW'(CLK_DIV - 2);

   typedef enum logic [1:0] {
      IDLE,
      LATCH,
      READ,
      DONE
   } state_t;

   state_t state_q, state_d;

   logic [TW-1:0] timer_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic          latch_d, sclk_d;
   logic          shift_en, load_en;

   logic [NUM_PADS-1:0]      sync1, sync2;
   logic [NUM_PADS-1:0][7:0] shreg;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      latch_d  = 1'b0;
      sclk_d   = 1'b0;
      shift_en = 1'b0;
      load_en  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (timer_q == '0) begin
               state_d = LATCH;
               cnt_d   = '0;
               latch_d = 1'b1;
            end
         end
         LATCH: begin
            if (cnt_q == C_LAST) begin
               state_d = READ;
               cnt_d   = '0;
               bit_d   = '0;
            end else begin
               cnt_d   = cnt_q + CW'(1);
               latch_d = 1'b1;
            end
         end
         READ: begin
            // sample lands on the edge that opens the last low cycle
            shift_en = (cnt_q == C_SAMPLE);
            if (cnt_q == C_LAST) begin
               cnt_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = DONE;
                  load_en = 1'b1;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d  = cnt_q + CW'(1);
               sclk_d = (cnt_d >= C_HIGH);
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         cnt_q     <= '0;
         bit_q     <= '0;
         nes_latch <= 1'b0;
         nes_clk   <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= (timer_q == T_LAST) ? '0 : timer_q + TW'(1);
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         nes_latch <= latch_d;
         nes_clk   <= sclk_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '1;
         sync2 <= '1;
         shreg <= '0;
      end else begin
         sync1 <= nes_data;
         sync2 <= sync1;
         if (shift_en) begin
            for (int k = 0; k < NUM_PADS; k++)
               shreg[k] <= {~sync2[k], shreg[k][7:1]};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buttons <= '0;
         valid   <= 1'b0;
`ifdef NES_PAD_EDGE_DETECT_EN
         pressed <= '0;
`endif
      end else begin
         valid <= load_en;
         if (load_en)
            buttons <= shreg;
`ifdef NES_PAD_EDGE_DETECT_EN
         pressed <= load_en ? (shreg & ~buttons) : '0;
`endif
      end
   end

endmodule

// File: tb/tb_nes_pad_poller.sv
// Directed bench for nes_pad_poller with a 4021 shift-register model per pad.
// Covers framing, bit order, hold, mid-frame change, async reset, glitch, edge detect.
module tb_nes_pad_poller;

   localparam int NP = 2;
   localparam int CD = 4;
   localparam int PP = 100;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NP-1:0] nes_data;
   logic          nes_latch;
   logic          nes_clk;
   logic [15:0]   buttons;
   logic          valid;
`ifdef NES_PAD_EDGE_DETECT_EN
   logic [15:0]   pressed;
`endif

   int errors = 0;
   int checks = 0;
   int e;

   logic [7:0] btn [2];
   logic [7:0] sr [2] = '{8'hFF, 8'hFF};
   logic [1:0] glitch = 2'b00;

   nes_pad_poller #(
      .NUM_PADS(NP),
      .CLK_DIV(CD),
      .POLL_PERIOD(PP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .nes_data(nes_data),
      .nes_latch(nes_latch),
      .nes_clk(nes_clk),
      .buttons(buttons),
`ifdef NES_PAD_EDGE_DETECT_EN
      .pressed(pressed),
`endif
      .valid(valid)
   );

   always #5 clk = ~clk;

   // frame-relative edge index: 0 on the first edge after reset release
   always @(posedge clk or posedge rst) begin
      if (rst) e <= -1;
      else e <= e + 1;
   end

   always @(posedge nes_clk or posedge nes_latch) begin
      for (int k = 0; k < 2; k++) begin
         if (nes_latch) sr[k] <= ~btn[k];
         else sr[k] <= {1'b1, sr[k][7:1]};
      end
   end

   assign nes_data = {sr[1][0], sr[0][0]} ^ glitch;

   task automatic wait_edge(input int k);
      int budget;
      budget = 0;
      while (e != k && budget < 2000) begin
         @(posedge clk);
         #1;
         budget++;
      end
      if (e != k) begin
         checks++;
         errors++;
         $display("FAIL wait_edge timeout e=%0d want %0d", e, k);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_frame_seq(input int base, input logic [15:0] nb,
                                 input logic [15:0] ob);
      logic       el, ec, ev;
      logic [15:0] eb;
      for (int k = 0; k <= 72; k++) begin
         wait_edge(base + k);
         el = (k < 8);
         ec = (k >= 8 && k < 72 && ((k - 8) % 8) >= 4);
         ev = (k == 72);
         eb = (k == 72) ? nb : ob;
         checks++;
         if (nes_latch !== el) begin
            errors++;
            $display("FAIL latch e=%0d got %b exp %b", k, nes_latch, el);
         end
         checks++;
         if (nes_clk !== ec) begin
            errors++;
            $display("FAIL nes_clk e=%0d got %b exp %b", k, nes_clk, ec);
         end
         checks++;
         if (valid !== ev) begin
            errors++;
            $display("FAIL valid e=%0d got %b exp %b", k, valid, ev);
         end
         checks++;
         if (buttons !== eb) begin
            errors++;
            $display("FAIL buttons e=%0d got %h exp %h", k, buttons, eb);
         end
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (nes_latch !== 1'b0) begin
         errors++;
         $display("FAIL rst_latch got %b exp 0", nes_latch);
      end
      checks++;
      if (nes_clk !== 1'b0) begin
         errors++;
         $display("FAIL rst_clk got %b exp 0", nes_clk);
      end
      checks++;
      if (buttons !== 16'h0000) begin
         errors++;
         $display("FAIL rst_buttons got %h exp 0000", buttons);
      end
      checks++;
      if (valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_valid got %b exp 0", valid);
      end
   endtask

   task automatic test_idle();
      btn[0] = 8'h00;
      btn[1] = 8'h00;
      do_reset();
      test_frame_seq(0, 16'h0000, 16'h0000);
      wait_edge(73);
      checks++;
      if (valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_valid73 got %b exp 0", valid);
      end
      wait_edge(99);
      checks++;
      if (nes_latch !== 1'b0) begin
         errors++;
         $display("FAIL idle_latch99 got %b exp 0", nes_latch);
      end
      wait_edge(100);
      checks++;
      if (nes_latch !== 1'b1) begin
         errors++;
         $display("FAIL idle_latch100 got %b exp 1", nes_latch);
      end
   endtask

   task automatic test_press_hold();
      btn[0] = 8'h81;
      btn[1] = 8'h08;
      do_reset();
      test_frame_seq(0, 16'h0881, 16'h0000);
      wait_edge(73);
      checks++;
      if (valid !== 1'b0) begin
         errors++;
         $display("FAIL press_valid73 got %b exp 0", valid);
      end
      wait_edge(99);
      checks++;
      if (buttons !== 16'h0881) begin
         errors++;
         $display("FAIL hold99 got %h exp 0881", buttons);
      end
      test_frame_seq(100, 16'h0881, 16'h0881);
   endtask

   task automatic test_midframe_change();
      btn[0] = 8'h81;
      btn[1] = 8'h08;
      do_reset();
      wait_edge(40);
      btn[0] = 8'h10;
      wait_edge(72);
      checks++;
      if (valid !== 1'b1 || buttons !== 16'h0881) begin
         errors++;
         $display("FAIL midchg_f0 got %b/%h exp 1/0881", valid, buttons);
      end
      wait_edge(171);
      checks++;
      if (buttons !== 16'h0881) begin
         errors++;
         $display("FAIL midchg_hold got %h exp 0881", buttons);
      end
      wait_edge(172);
      checks++;
      if (valid !== 1'b1 || buttons !== 16'h0810) begin
         errors++;
         $display("FAIL midchg_f1 got %b/%h exp 1/0810", valid, buttons);
      end
   endtask

   task automatic test_mid_reset();
      wait_edge(244);
      checks++;
      if (nes_clk !== 1'b1 || buttons !== 16'h0810) begin
         errors++;
         $display("FAIL prereset got %b/%h exp 1/0810", nes_clk, buttons);
      end
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({nes_clk, nes_latch, valid} !== 3'b000 || buttons !== 16'h0000) begin
         errors++;
         $display("FAIL async_rst got %b%b%b/%h exp 000/0000",
                  nes_clk, nes_latch, valid, buttons);
      end
      do_reset();
      test_frame_seq(0, 16'h0810, 16'h0000);
   endtask

   task automatic test_glitch();
      btn[0] = 8'h81;
      btn[1] = 8'h08;
      do_reset();
      wait_edge(12);
      #4;
      glitch = 2'b11;
      wait_edge(13);
      #4;
      glitch = 2'b00;
      wait_edge(72);
      checks++;
      if (valid !== 1'b1 || buttons !== 16'h0881) begin
         errors++;
         $display("FAIL glitch got %b/%h exp 1/0881", valid, buttons);
      end
   endtask

`ifdef NES_PAD_EDGE_DETECT_EN
   task automatic test_edge_detect();
      logic [7:0] seq [5] = '{8'h00, 8'h03, 8'h01, 8'h05, 8'h05};
      logic [15:0] exp [4] = '{16'h0000, 16'h0003, 16'h0000, 16'h0004};
      btn[0] = seq[0];
      btn[1] = 8'h00;
      do_reset();
      for (int f = 0; f < 4; f++) begin
         wait_edge(100 * f + 71);
         checks++;
         if (pressed !== 16'h0000) begin
            errors++;
            $display("FAIL pressed_pre f=%0d got %h exp 0000", f, pressed);
         end
         wait_edge(100 * f + 72);
         checks++;
         if (valid !== 1'b1 || pressed !== exp[f]) begin
            errors++;
            $display("FAIL pressed f=%0d got %b/%h exp 1/%h", f, valid,
                     pressed, exp[f]);
         end
         wait_edge(100 * f + 73);
         checks++;
         if (pressed !== 16'h0000) begin
            errors++;
            $display("FAIL pressed_post f=%0d got %h exp 0000", f, pressed);
         end
         btn[0] = seq[f + 1];
      end
   endtask
`endif

   initial begin
      btn[0] = 8'h00;
      btn[1] = 8'h00;
      test_reset();
      test_idle();
      test_press_hold();
      test_midframe_change();
      test_mid_reset();
      test_glitch();
`ifdef NES_PAD_EDGE_DETECT_EN
      test_edge_detect();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
